// File: rtl/apb_rev_b_master_arb_pkg.sv
// Shared types for the APB rev B master arbiter: FSM state encoding and
// default bus widths.
package apb_pkg;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2
    } apb_state_e;

    localparam int APB_AW = 32;
    localparam int APB_DW = 32;

endpackage

// File: rtl/apb_rev_b_master_arb_if.sv
// APB rev B bus bundle (no pprot/pstrb). The master drives address/control,
// and the slave returns ready, read data and error.
interface apb_rev_b_if #(
    parameter int AW = apb_pkg::APB_AW,
    parameter int DW = apb_pkg::APB_DW
) ();

    logic [AW-1:0] paddr;
    logic          pselx;
    logic          penable;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic          pready;
    logic [DW-1:0] prdata;
    logic          pslverr;

    modport master (
        output paddr, pselx, penable, pwrite, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, pselx, penable, pwrite, pwdata,
        output pready, prdata, pslverr
    );

endinterface

// File: rtl/apb_rev_b_master_arb_rr_arbiter.sv
// Round-robin arbiter. Priority starts one past the last winner and wraps.
// The pointer moves only when the caller accepts the grant.
module apb_rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic [NREQ-1:0]         req,
    input  logic                    advance,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grant_idx,
    output logic                    any_req
);
    localparam int PW = $clog2(NREQ);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] cand;

    always_comb begin
        grant_idx = '0;
        cand      = '0;
        // Scan from the lowest-priority slot back toward ptr+1 so the nearest request is kept
        for (int i = NREQ; i >= 1; i--) begin
            cand = PW'((int'(ptr_q) + i) % NREQ);
            if (req[cand]) begin
                grant_idx = cand;
            end
        end
        any_req = |req;
        grant   = any_req ? (NREQ'(1) << grant_idx) : '0;
        ptr_d   = advance ? grant_idx : ptr_q;
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            ptr_q <= PW'(NREQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/apb_rev_b_master_arb.sv
// Shares one APB rev B master port among NREQ requesters. It has a round-robin
// grant, an IDLE/SETUP/ACCESS sequencer, and an optional hung-slave timeout.
module apb_rev_b_master_arb
    import apb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int AW      = APB_AW,
    parameter int DW      = APB_DW,
    parameter int TIMEOUT = 256
) (
    input  logic               pclk,
    input  logic               preset,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_rdata,
    output logic               rsp_err,
    apb_rev_b_if.master        apb
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic [AW-1:0] addr_arr  [NREQ];
    logic [DW-1:0] wdata_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = req_addr[gi*AW +: AW];
        assign wdata_arr[gi] = req_wdata[gi*DW +: DW];
    end

    logic [NREQ-1:0] grant;
    logic [PW-1:0]   grant_idx;
    logic            any_req;
    logic            handshake;

    apb_state_e      state_q,     state_d;
    logic [AW-1:0]   paddr_q,     paddr_d;
    logic [DW-1:0]   pwdata_q,    pwdata_d;
    logic            pwrite_q,    pwrite_d;
    logic            psel_q,      psel_d;
    logic            penable_q,   penable_d;
    logic [PW-1:0]   owner_q,     owner_d;
    logic [CW-1:0]   cnt_q,       cnt_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q,   rsp_err_d;

    apb_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .pclk      (pclk),
        .preset    (preset),
        .req       (req_valid),
        .advance   (handshake),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    assign handshake = (state_q == APB_IDLE) && any_req;
    assign req_ready = (state_q == APB_IDLE) ? grant : '0;

    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            APB_IDLE: begin
                if (handshake) begin
                    paddr_d   = addr_arr[grant_idx];
                    pwdata_d  = wdata_arr[grant_idx];
                    pwrite_d  = req_write[grant_idx];
                    owner_d   = grant_idx;
                    cnt_d     = '0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = APB_SETUP;
                end
            end
            APB_SETUP: begin
                penable_d = 1'b1;
                state_d   = APB_ACCESS;
            end
            APB_ACCESS: begin
                // pready is tested first so a reply on the limit cycle still counts as real
                if (apb.pready || ((TIMEOUT > 0) && (cnt_q == CNT_LAST))) begin
                    rsp_valid_d          = '0;
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_rdata_d          = (apb.pready && !pwrite_q) ? apb.prdata : '0;
                    rsp_err_d            = apb.pready ? apb.pslverr : 1'b1;
                    psel_d               = 1'b0;
                    penable_d            = 1'b0;
                    state_d              = APB_IDLE;
                end else if (TIMEOUT > 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = APB_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q     <= APB_IDLE;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            owner_q     <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign apb.paddr   = paddr_q;
    assign apb.pwdata  = pwdata_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.pselx   = psel_q;
    assign apb.penable = penable_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_apb_rev_b_master_arb.sv
// Directed bench for apb_rev_b_master_arb with four requesters and TIMEOUT = 4.
// Inputs change and outputs are sampled on the falling edge of pclk.
module tb_apb_rev_b_master_arb;
    import apb_pkg::*;

    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TO   = 4;

    logic                pclk = 1'b0;
    logic                preset = 1'b1;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ-1:0]     req_write;
    logic [NREQ*DW-1:0]  req_wdata;
    logic [NREQ-1:0]     rsp_valid;
    logic [DW-1:0]       rsp_rdata;
    logic                rsp_err;

    int checks = 0;
    int errors = 0;

    apb_rev_b_if #(.AW(AW), .DW(DW)) apb_bus ();

    apb_rev_b_master_arb #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TO)
    ) dut (
        .pclk      (pclk),
        .preset    (preset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_write (req_write),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .apb       (apb_bus)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Runs one transfer for requester r, starting on a falling edge in IDLE.
    // It returns on the falling edge of the response cycle.
    task automatic xfer(input int r, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input int waits, input logic [31:0] rd,
                        input logic err, input logic to, input logic keep, input string tag);
        logic [3:0]  onehot;
        int          n_acc;
        logic [31:0] exp_rd;
        logic        exp_err;
        onehot  = 4'b0001 << r;
        n_acc   = to ? TO : waits + 1;
        exp_rd  = (to || wr) ? 32'h0 : rd;
        exp_err = to ? 1'b1 : err;
        req_valid[r]          = 1'b1;
        req_write[r]          = wr;
        req_addr[r*AW +: AW]  = addr;
        req_wdata[r*DW +: DW] = wd;
        apb_bus.pready  = 1'b0;
        apb_bus.prdata  = rd;
        apb_bus.pslverr = err;
        #1;
        chk({tag, " req_ready"}, req_ready, onehot);
        @(negedge pclk);
        chk({tag, " setup psel/pen"}, {apb_bus.pselx, apb_bus.penable}, 2'b10);
        chk({tag, " setup paddr"}, apb_bus.paddr, addr);
        chk({tag, " setup pwrite"}, apb_bus.pwrite, wr);
        chk({tag, " setup pwdata"}, apb_bus.pwdata, wd);
        if (!keep) req_valid[r] = 1'b0;
        for (int k = 0; k < n_acc; k++) begin
            @(negedge pclk);
            chk({tag, " access psel/pen"}, {apb_bus.pselx, apb_bus.penable}, 2'b11);
            chk({tag, " access paddr"}, apb_bus.paddr, addr);
            if (k == 0) chk({tag, " busy req_ready"}, req_ready, 4'b0000);
            apb_bus.pready = (!to && (k == n_acc - 1));
        end
        @(negedge pclk);
        chk({tag, " rsp_valid"}, rsp_valid, onehot);
        chk({tag, " rsp_rdata"}, rsp_rdata, exp_rd);
        chk({tag, " rsp_err"}, rsp_err, exp_err);
        chk({tag, " end psel/pen"}, {apb_bus.pselx, apb_bus.penable}, 2'b00);
        apb_bus.pready = 1'b0;
    endtask

    initial begin
        req_valid       = '0;
        req_write       = '0;
        req_addr        = '0;
        req_wdata       = '0;
        apb_bus.pready  = 1'b0;
        apb_bus.prdata  = '0;
        apb_bus.pslverr = 1'b0;

        // Reset state
        repeat (2) @(negedge pclk);
        chk("reset psel/pen", {apb_bus.pselx, apb_bus.penable}, 2'b00);
        chk("reset paddr", apb_bus.paddr, 32'h0);
        chk("reset rsp_valid", rsp_valid, 4'b0000);
        chk("reset rsp_rdata", rsp_rdata, 32'h0);
        chk("reset rsp_err", rsp_err, 1'b0);
        preset = 1'b0;
        @(negedge pclk);
        chk("idle req_ready", req_ready, 4'b0000);
        chk("idle psel", apb_bus.pselx, 1'b0);

        // Single write, no wait states
        xfer(0, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 0, 32'h5555_AAAA, 1'b0, 1'b0, 1'b0, "wr0");
        @(negedge pclk);
        chk("wr0 rsp pulse ends", rsp_valid, 4'b0000);

        // Slave error on a write from requester 1
        xfer(1, 1'b1, 32'h0000_0100, 32'h0BAD_0001, 0, 32'h0, 1'b1, 1'b0, 1'b0, "slverr1");
        // Next transfer is clean: read with three wait states
        xfer(2, 1'b0, 32'h0000_0040, 32'h0000_0000, 3, 32'h1234_5678, 1'b0, 1'b0, 1'b0, "rd2");
        // Hung slave: timeout after exactly TO access cycles
        xfer(3, 1'b0, 32'h0000_0080, 32'h0000_0000, 0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, "tmo3");

        // Fairness: all requesters held high, expect 0,1,2,3,0,1,2,3
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            xfer(i % 4, logic'(i % 2), 32'h2000_0000 + 32'(i * 16), 32'hC0DE_0000 + 32'(i),
                 0, 32'hA5A5_0000 + 32'(i), 1'b0, 1'b0, 1'b1, $sformatf("rr%0d", i));
        end
        req_valid = 4'b0000;

        // pready arrives on the timeout limit cycle: the slave's reply wins
        xfer(0, 1'b0, 32'h3000_0000, 32'h0, 3, 32'h0BAD_F00D, 1'b1, 1'b0, 1'b0, "limit0");

        // Asynchronous reset during wait states
        req_valid[1]    = 1'b1;
        req_write[1]    = 1'b0;
        req_addr[AW +: AW] = 32'h4000_0000;
        apb_bus.pready  = 1'b0;
        #1;
        chk("rst req_ready", req_ready, 4'b0010);
        @(negedge pclk);
        req_valid = 4'b0000;
        repeat (2) @(negedge pclk);
        chk("rst pre access", {apb_bus.pselx, apb_bus.penable}, 2'b11);
        @(posedge pclk);
        #2;
        preset = 1'b1;
        #1;
        chk("rst async psel/pen", {apb_bus.pselx, apb_bus.penable}, 2'b00);
        chk("rst async rsp_valid", rsp_valid, 4'b0000);
        repeat (2) @(negedge pclk);
        chk("rst held rsp_valid", rsp_valid, 4'b0000);
        preset    = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("rst first winner", req_ready, 4'b0001);
        @(negedge pclk);
        chk("rst no rsp", rsp_valid, 4'b0000);
        chk("rst new setup", {apb_bus.pselx, apb_bus.penable}, 2'b10);
        req_valid = 4'b0000;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_rev_b_master_arb.md
Name: apb_rev_b_master_arb

Overview:
- Shares one APB rev B master port among NREQ local requesters.
- Round-robin arbitration picks one request at a time. The block then sequences the IDLE/SETUP/ACCESS protocol, absorbs pready wait states, and returns prdata/pslverr to the winning requester.
- A programmable timeout ends a transfer against a hung slave.
- Sits between bus-master clients (CPU bridge, DMA, config engines) and the APB interconnect. Drives the master side of apb_rev_b_if.

Parameters:
- NREQ, 4, number of requesters (2..16).
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 256, max ACCESS cycles without pready; 0 disables the timeout.

Ports:
- pclk  in  1  clock.
- preset  in  1  reset, asynchronous, active-high.
- req_valid  in  NREQ  per-requester transfer request.
- req_ready  out  NREQ  request accepted (one-hot or zero).
- req_addr  in  NREQ*AW  packed addresses; requester i at slice [i*AW +: AW].
- req_write  in  NREQ  1 = write.
- req_wdata  in  NREQ*DW  packed write data.
- rsp_valid  out  NREQ  one-cycle completion pulse to the owning requester.
- rsp_rdata  out  DW  read data, shared; qualified by rsp_valid.
- rsp_err  out  1  error (pslverr or timeout), qualified by rsp_valid.
- paddr  out  AW  APB address.
- pselx  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  DW  APB write data.
- pready  in  1  APB ready.
- prdata  in  DW  APB read data.
- pslverr  in  1  APB slave error.

Behaviour:
Interface and reset:
- Single clock pclk; preset is asynchronous, active-high.
- While preset is high: state = IDLE, all APB outputs 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, RR pointer = NREQ-1 (so requester 0 wins first), timeout counter = 0.
- Reset mid-transfer aborts immediately: pselx/penable drop asynchronously and no rsp_valid is issued.

State machine, IDLE -> SETUP -> ACCESS -> IDLE:
- IDLE:
  - pselx = 0, penable = 0.
  - req_ready[g] = 1 combinationally for the RR winner g when any req_valid is set; all other req_ready bits are 0.
  - On the handshake, register paddr/pwrite/pwdata from slice g, record owner = g, move pointer to g, go to SETUP.
- SETUP (exactly 1 cycle): pselx = 1, penable = 0. Next state is ACCESS.
- ACCESS: pselx = 1, penable = 1; paddr/pwrite/pwdata held stable.
  - On pready = 1: next cycle, rsp_valid[owner] = 1 for one cycle, rsp_rdata = prdata (0 for writes), rsp_err = pslverr. pselx/penable = 0; go to IDLE.
  - Timeout, when TIMEOUT > 0: the counter increments each ACCESS cycle with pready = 0. When it reaches TIMEOUT, the transfer ends as if pready were seen, with rsp_err = 1 and rsp_rdata = 0.
  - The counter clears on SETUP entry.
  - If pready arrives in the same cycle as the timeout limit, pready wins and the real pslverr/prdata are used.

Timing and arbitration:
- Minimum transfer: handshake cycle, SETUP, ACCESS, then rsp_valid one cycle after the completing ACCESS cycle.
- No new request is accepted while not in IDLE; req_ready = 0 outside IDLE. The IDLE cycle in which rsp_valid is driven may also accept the next request.
- Round robin: search starts at pointer+1 mod NREQ and wraps; the first set req_valid wins. The pointer updates only on handshake.
- A requester that drops req_valid before its grant is simply skipped.
- A requester's slice contents matter only in its handshake cycle.

Other rules:
- pwdata is held at its captured value during reads and is ignored by slaves.
- paddr and pwdata are not zeroed between transfers; they hold their last value.
- Widths: counter width is $clog2(TIMEOUT+1), minimum 1; pointer width is $clog2(NREQ).

Decomposition:
- Shared package apb_pkg: state enum apb_state_e {APB_IDLE, APB_SETUP, APB_ACCESS}; default AW/DW localparams.
- Sub-module apb_rr_arbiter (params NREQ). Inputs: req vector, advance strobe. Outputs: one-hot grant plus encoded index. Holds the pointer internally.
- The top level holds the FSM, capture registers and timeout counter.

Test Plan:
1. Single write: req_valid = 0001, addr 0x1000_0010, wdata 0xDEAD_BEEF, pready tied 1 -> SETUP then ACCESS with penable high 1 cycle; rsp_valid = 0001 the next cycle; rsp_err = 0.
2. Read with 3 wait states: requester 2 reads 0x0000_0040, pready low 3 ACCESS cycles, prdata = 0x1234_5678 -> paddr stable for 4 ACCESS cycles; rsp_valid = 0100; rsp_rdata = 0x1234_5678.
3. Fairness: all four req_valid held high, 8 transfers -> grant order 0, 1, 2, 3, 0, 1, 2, 3; req_ready never multi-hot.
4. Slave error: pslverr = 1 with pready on a write from requester 1 -> rsp_valid = 0010, rsp_err = 1; next transfer unaffected.
5. Timeout: TIMEOUT = 4, pready stuck 0 -> exactly 4 ACCESS cycles; rsp_err = 1, rsp_rdata = 0; pselx low next. Repeat with pready rising on the 4th cycle -> real response returned, rsp_err = pslverr.
6. Reset mid-ACCESS: assert preset asynchronously during wait states -> pselx/penable go 0 without a clock edge; no rsp_valid; after release requester 0 wins first.
